// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the seconds countdown timer.
package timer_pkg;

    localparam int START_VAL_DEF = 24;
    localparam int BCD_W         = 4;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd_t;

    // Fixed compare/subtract chain; nine steps cover any value up to 99.
    function automatic bcd_t to_bcd(input logic [6:0] v);
        logic [6:0] r;
        bcd_t       res;
        r        = v;
        res.tens = '0;
        for (int i = 0; i < 9; i++) begin
            if (r >= 7'd10) begin
                r        = r - 7'd10;
                res.tens = res.tens + 4'd1;
            end
        end
        res.ones = BCD_W'(r);
        return res;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control pulses in, count/BCD/status out for the countdown timer.
interface countdown_timer_if #(parameter int WIDTH = 5);
    import timer_pkg::*;

    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    logic             running;
    logic             expired;
    logic             done;

    modport master (
        output start, stop, load, load_val,
        input  count, tens, ones, running, expired, done
    );

    modport slave (
        input  start, stop, load, load_val,
        output count, tens, ones, running, expired, done
    );

endinterface

// File: rtl/countdown_timer_tick_edge_sync.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous level input.
module tick_edge_sync (
    input  logic cin,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1, sync2, prev;

    // The pulse is registered so a rise sampled at edge N is acted on at edge N+3.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= async_in;
            sync2      <= sync1;
            prev       <= sync2;
            rise_pulse <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown controller: start/stop/load FSM, count/reload registers, BCD digits.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int START_VAL = START_VAL_DEF
) (
    input  logic             cin,
    input  logic             rst_n,
    input  logic             tick_in,
    countdown_timer_if.slave bus
);

    localparam logic [WIDTH-1:0] START_CNT = WIDTH'(START_VAL);
    localparam bcd_t             START_BCD = to_bcd(7'(START_VAL));

    logic             sec_tick;
    state_t           state_q, state_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic [WIDTH-1:0] reload_q, reload_n;
    bcd_t             bcd_q, bcd_n;
    logic             running_q, expired_q, done_q, done_n;

    tick_edge_sync u_tick (
        .cin        (cin),
        .rst_n      (rst_n),
        .async_in   (tick_in),
        .rise_pulse (sec_tick)
    );

    // Priority: load > stop > start > sec_tick. A start while already running is a no-op.
    always_comb begin
        state_n  = state_q;
        count_n  = count_q;
        reload_n = reload_q;
        done_n   = 1'b0;
        if (bus.load) begin
            reload_n = bus.load_val;
            count_n  = bus.load_val;
            state_n  = IDLE;
        end else if (bus.stop) begin
            if (state_q == RUN) state_n = PAUSED;
        end else if (bus.start && state_q != RUN) begin
            case (state_q)
                IDLE: begin
                    if (count_q == '0) begin
                        state_n = EXPIRED;
                        done_n  = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
                PAUSED: state_n = RUN;
                EXPIRED: begin
                    count_n = reload_q;
                    if (reload_q == '0) done_n  = 1'b1;
                    else                state_n = RUN;
                end
                default: state_n = state_q;
            endcase
        end else if (sec_tick && state_q == RUN && count_q != '0) begin
            count_n = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
                state_n = EXPIRED;
                done_n  = 1'b1;
            end
        end
        bcd_n = to_bcd(7'(count_n));
    end

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= START_CNT;
            reload_q  <= START_CNT;
            bcd_q     <= START_BCD;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            count_q   <= count_n;
            reload_q  <= reload_n;
            bcd_q     <= bcd_n;
            running_q <= (state_n == RUN);
            expired_q <= (state_n == EXPIRED);
            done_q    <= done_n;
        end
    end

    assign bus.count   = count_q;
    assign bus.tens    = bcd_q.tens;
    assign bus.ones    = bcd_q.ones;
    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.done    = done_q;

endmodule
